mpadd_arbiter: RTL and testbench
================================

# mpadd_arbiter

Two-requester round-robin arbiter and sequencer for one shared multi-precision adder engine. It accepts add requests from two clients, latches the winner's operands, and drives the engine's write/start/ready handshake. It captures the WIDTH+1-bit sum and returns it to the granted client with a one-cycle done pulse. A watchdog aborts a transaction whose engine never asserts ready. The block sits between client logic and either the single-cycle parallel adder or the 32-bit-word serial adder, unchanged for both.

## Interface
- WIDTH, 256, operand width; sum is WIDTH+1 bits
- TIMEOUT, 15, max WAIT cycles without add_ready before abort (≥1)

- CLK  in  1  clock, all logic on rising edge
- RST_N  in  1  reset, synchronous, active-low
- req0, req1  in  1 each  request level; held until matching done
- a0, b0, a1, b1  in  WIDTH each  operands; sampled only in the grant cycle
- done0, done1  out  1 each  one-cycle completion pulse to the granted client
- s_out  out  WIDTH+1  result; valid in done cycle, held until next done
- err  out  1  high with done when the transaction timed out
- busy  out  1  high in every state except IDLE
- grant  out  2  one-hot current owner; 00 in IDLE
- add_a, add_b  out  WIDTH each  operands to engine (registered)
- add_write  out  1  operand-load strobe to engine
- add_start  out  1  start strobe to engine
- add_s  in  WIDTH+1  engine sum
- add_ready  in  1  engine completion pulse

## Operation
- States: IDLE → WRITE → START → WAIT → RESP → IDLE.
- IDLE: if any req is sampled high, arbitrate, latch the winner's a/b into add_a/add_b, set grant, and go to WRITE.
- Round-robin: a single request wins outright. On a tie, the client not granted last wins. The last-grant pointer resets to client 1, so client 0 wins the first tie. The pointer updates on every grant.
- WRITE: add_write=1 for exactly this cycle. Go to START.
- START: add_start=1 for exactly this cycle. Clear the watchdog counter. Go to WAIT.
- WAIT:
  - add_ready sampled high: capture add_s into s_out, err=0, go to RESP.
  - Otherwise increment the counter. On the TIMEOUT-th WAIT cycle without ready: s_out=0, err=1, go to RESP.
- RESP: done of the granted client =1 for this cycle only. Then go to IDLE; grant returns to 00 on the IDLE entry.
- add_ready outside WAIT is ignored.
- Operands are latched at grant. Later changes on a*/b* do not affect the transaction.
- A client dropping req mid-transaction does not abort it; done still pulses and may be ignored.
- add_write and add_start are never high together, and never high outside WRITE/START.
- Width rule: s_out is taken verbatim from add_s, including carry bit WIDTH. No arithmetic is done in this block.

## Timing
- Reset (RST_N low at an edge): state=IDLE, last-grant=1, watchdog=0. All outputs 0: done0/1, err, busy, grant, add_write, add_start, add_a, add_b, s_out.
- Reset mid-transaction: the transaction is dropped, no done is issued, and the block restarts from IDLE with the values above.
- Request sampled at the edge ending cycle N (in IDLE):
  - cycle N+1: WRITE
  - cycle N+2: START
  - from N+3: WAIT
- Parallel engine: ready is high in N+3, done is high in N+4. Latency is 4 cycles from sample to done.
- Serial engine: ready is high in N+10, done is high in N+11.
- Timeout: with ready never arriving, WAIT spans N+3..N+2+TIMEOUT, and done+err are high in N+3+TIMEOUT (N+18 at the default).
- Requester handshake: the client drops req at the edge ending the done cycle. A req still high in the IDLE cycle after RESP is a new request.
- Back-to-back: with both clients requesting continuously, grants alternate. The minimum gap between consecutive done pulses is 5 cycles (parallel engine).

## Test plan
- Single request, parallel engine: req0, a0=1, b0=2 → add_write in N+1, add_start in N+2, done0 in N+4, s_out=3, err=0, grant back to 00 in N+5.
- Carry-out: a1=2^256−1, b1=1 → done1 with s_out=2^256 (bit 256 set, bits 255:0 zero).
- Tie and fairness: req0 and req1 raised in the same cycle and held (each re-raised after its done) → first done0, then done1, strictly alternating over 6 transactions.
- Serial engine end-to-end: 100 LFSR operand pairs per client → every s_out matches {0,a}+{0,b}, and done is 11 cycles after the sample.
- Timeout: engine add_ready tied 0 → done0 with err=1, s_out=0 in N+18. The next request then completes normally.
- Reset mid-WAIT: RST_N low for one edge during WAIT → no done, all outputs 0 in the next cycle. A fresh req0 is granted normally (pointer reset, so client 0 wins the next tie).

Source files
------------

// File: rtl/mpadd_arbiter.sv
// Round-robin arbiter and sequencer sharing one multi-precision adder engine between two clients.
// Drives the engine write/start handshake, captures the sum, and aborts via a watchdog.
module mpadd_arbiter #(
    parameter int unsigned WIDTH   = 256,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             req0,
    input  logic             req1,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    output logic             done0,
    output logic             done1,
    output logic [WIDTH:0]   s_out,
    output logic             err,
    output logic             busy,
    output logic [1:0]       grant,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    output logic             add_write,
    output logic             add_start,
    input  logic [WIDTH:0]   add_s,
    input  logic             add_ready
);

    localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT - 1);

    typedef enum logic [2:0] {StIdle, StWrite, StStart, StWait, StResp} state_e;

    state_e           state_q, state_d;
    logic             last_q, last_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [1:0]       grant_q, grant_d;
    logic [WIDTH-1:0] add_a_q, add_a_d, add_b_q, add_b_d;
    logic [WIDTH:0]   s_out_q, s_out_d;
    logic             done0_q, done0_d, done1_q, done1_d;
    logic             err_q, err_d, busy_q, busy_d;
    logic             add_write_q, add_write_d, add_start_q, add_start_d;
    logic             win;

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        cnt_d       = cnt_q;
        grant_d     = grant_q;
        add_a_d     = add_a_q;
        add_b_d     = add_b_q;
        s_out_d     = s_out_q;
        done0_d     = 1'b0;
        done1_d     = 1'b0;
        err_d       = 1'b0;
        add_write_d = 1'b0;
        add_start_d = 1'b0;
        // win selects client 1; on a tie the client not granted last goes first
        win         = (req0 && req1) ? ~last_q : req1;

        case (state_q)
            StIdle: begin
                if (req0 || req1) begin
                    last_d      = win;
                    grant_d     = win ? 2'b10 : 2'b01;
                    add_a_d     = win ? a1 : a0;
                    add_b_d     = win ? b1 : b0;
                    add_write_d = 1'b1;
                    state_d     = StWrite;
                end
            end
            StWrite: begin
                add_start_d = 1'b1;
                state_d     = StStart;
            end
            StStart: begin
                cnt_d   = '0;
                state_d = StWait;
            end
            StWait: begin
                if (add_ready) begin
                    s_out_d = add_s;
                    done0_d = grant_q[0];
                    done1_d = grant_q[1];
                    state_d = StResp;
                end else if (cnt_q == CntMax) begin
                    s_out_d = '0;
                    err_d   = 1'b1;
                    done0_d = grant_q[0];
                    done1_d = grant_q[1];
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StResp: begin
                grant_d = 2'b00;
                state_d = StIdle;
            end
            default: begin
                grant_d = 2'b00;
                state_d = StIdle;
            end
        endcase

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q     <= StIdle;
            last_q      <= 1'b1;
            cnt_q       <= '0;
            grant_q     <= 2'b00;
            add_a_q     <= '0;
            add_b_q     <= '0;
            s_out_q     <= '0;
            done0_q     <= 1'b0;
            done1_q     <= 1'b0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
            add_write_q <= 1'b0;
            add_start_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
            grant_q     <= grant_d;
            add_a_q     <= add_a_d;
            add_b_q     <= add_b_d;
            s_out_q     <= s_out_d;
            done0_q     <= done0_d;
            done1_q     <= done1_d;
            err_q       <= err_d;
            busy_q      <= busy_d;
            add_write_q <= add_write_d;
            add_start_q <= add_start_d;
        end
    end

    assign done0     = done0_q;
    assign done1     = done1_q;
    assign s_out     = s_out_q;
    assign err       = err_q;
    assign busy      = busy_q;
    assign grant     = grant_q;
    assign add_a     = add_a_q;
    assign add_b     = add_b_q;
    assign add_write = add_write_q;
    assign add_start = add_start_q;

endmodule

// File: tb/tb_mpadd_arbiter.sv
// Self-checking bench for mpadd_arbiter: directed steps plus random operands, with an
// emulated parallel/serial/dead adder engine and a plain-arithmetic sum model.
module tb_mpadd_arbiter;

    localparam int W = 256;

    logic         CLK, RST_N;
    logic         req0, req1;
    logic [W-1:0] a0, b0, a1, b1;
    logic         done0, done1, err, busy, add_write, add_start, add_ready;
    logic [W:0]   s_out, add_s;
    logic [1:0]   grant;
    logic [W-1:0] add_a, add_b;

    int total = 0;
    int bad   = 0;
    int eng_mode = 0;  // 0 parallel, 1 serial, 2 never ready
    int eng_cnt  = 0;

    mpadd_arbiter #(.WIDTH(W), .TIMEOUT(15)) dut (
        .CLK(CLK), .RST_N(RST_N), .req0(req0), .req1(req1),
        .a0(a0), .b0(b0), .a1(a1), .b1(b1),
        .done0(done0), .done1(done1), .s_out(s_out), .err(err), .busy(busy),
        .grant(grant), .add_a(add_a), .add_b(add_b), .add_write(add_write),
        .add_start(add_start), .add_s(add_s), .add_ready(add_ready)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #2000000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

    // Engine emulation: ready one cycle after start (parallel) or eight cycles (serial)
    initial begin
        add_ready = 1'b0;
        add_s     = '0;
        forever begin
            @(posedge CLK);
            #1;
            add_ready = 1'b0;
            if (eng_cnt > 0) begin
                eng_cnt--;
                if (eng_cnt == 0) begin
                    add_ready = 1'b1;
                    add_s     = {1'b0, add_a} + {1'b0, add_b};
                end
            end
            if (add_start === 1'b1 && eng_mode != 2) eng_cnt = (eng_mode == 0) ? 1 : 8;
        end
    end

    function automatic logic [W-1:0] rnd();
        logic [W-1:0] r;
        for (int i = 0; i < W / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [W:0] model_sum(input logic [W-1:0] a, input logic [W-1:0] b);
        return {1'b0, a} + {1'b0, b};
    endfunction

    task automatic check(input string tag, input logic [W:0] obs, input logic [W:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_done0"}, (W+1)'(done0), '0);
        check({tag, "_done1"}, (W+1)'(done1), '0);
        check({tag, "_err"}, (W+1)'(err), '0);
        check({tag, "_busy"}, (W+1)'(busy), '0);
        check({tag, "_grant"}, (W+1)'(grant), '0);
        check({tag, "_write"}, (W+1)'(add_write), '0);
        check({tag, "_start"}, (W+1)'(add_start), '0);
        check({tag, "_add_a"}, (W+1)'(add_a), '0);
        check({tag, "_add_b"}, (W+1)'(add_b), '0);
        check({tag, "_s_out"}, s_out, '0);
    endtask

    // Called #1 into the sample cycle N; runs one transaction for client c to its done.
    task automatic run_txn(input int c, input logic [W-1:0] a, input logic [W-1:0] b,
                           input int exp_lat, input bit exp_err, input string tag);
        logic [W:0] exp_s;
        int lat;
        bit seen;
        exp_s = exp_err ? '0 : model_sum(a, b);
        if (c == 0) begin a0 = a; b0 = b; req0 = 1'b1; end
        else begin a1 = a; b1 = b; req1 = 1'b1; end
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 40) begin
            tick();
            lat++;
            if (lat == 1) begin
                check({tag, "_w_write"}, (W+1)'(add_write), 1);
                check({tag, "_w_grant"}, (W+1)'(grant), (W+1)'(c == 0 ? 2'b01 : 2'b10));
                // operands must already be latched; scramble the inputs
                if (c == 0) begin a0 = rnd(); b0 = rnd(); end
                else begin a1 = rnd(); b1 = rnd(); end
            end
            if (lat == 2) begin
                check({tag, "_s_start"}, (W+1)'(add_start), 1);
                check({tag, "_s_write"}, (W+1)'(add_write), 0);
            end
            if ((c == 0 ? done0 : done1) === 1'b1) seen = 1'b1;
        end
        check({tag, "_lat"}, (W+1)'(lat), (W+1)'(exp_lat));
        check({tag, "_sum"}, s_out, exp_s);
        check({tag, "_err"}, (W+1)'(err), (W+1)'(exp_err));
        check({tag, "_other"}, (W+1)'(c == 0 ? done1 : done0), 0);
        tick();
        if (c == 0) req0 = 1'b0; else req1 = 1'b0;
        check({tag, "_idle_grant"}, (W+1)'(grant), 0);
        check({tag, "_idle_busy"}, (W+1)'(busy), 0);
        check({tag, "_idle_done"}, (W+1)'(c == 0 ? done0 : done1), 0);
    endtask

    // Waits for the next done pulse; returns client id (-1 on time-out) and cycles waited.
    task automatic wait_done(output int who, output int gap);
        who = -1;
        gap = 0;
        while (who < 0 && gap < 40) begin
            tick();
            gap++;
            if (done0 === 1'b1) who = 0;
            else if (done1 === 1'b1) who = 1;
        end
    endtask

    initial begin
        logic [W-1:0] ta0, tb0, ta1, tb1;
        int who, gap, cnt;

        RST_N = 1'b0;
        req0  = 1'b0;
        req1  = 1'b0;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0;
        tick();
        tick();
        check_all_zero("reset");
        RST_N = 1'b1;
        tick();

        run_txn(0, 256'd1, 256'd2, 4, 1'b0, "single");
        tick();
        run_txn(1, {W{1'b1}}, 256'd1, 4, 1'b0, "carry");
        check("carry_bit", s_out, {1'b1, {W{1'b0}}});

        // Both held continuously: alternate starting with client 0, 5-cycle spacing
        ta0 = rnd(); tb0 = rnd(); ta1 = rnd(); tb1 = rnd();
        a0 = ta0; b0 = tb0; a1 = ta1; b1 = tb1;
        req0 = 1'b1;
        req1 = 1'b1;
        for (int k = 0; k < 6; k++) begin
            wait_done(who, gap);
            check("tie_who", (W+1)'(who), (W+1)'(k % 2));
            check("tie_gap", (W+1)'(gap), (W+1)'(k == 0 ? 4 : 5));
            check("tie_sum", s_out, (k % 2 == 0) ? model_sum(ta0, tb0) : model_sum(ta1, tb1));
        end
        tick();
        req0 = 1'b0;
        req1 = 1'b0;
        tick();
        check("tie_end_grant", (W+1)'(grant), 0);

        eng_mode = 1;
        for (int i = 0; i < 200; i++) run_txn(i % 2, rnd(), rnd(), 11, 1'b0, "serial");

        eng_mode = 2;
        run_txn(0, rnd(), rnd(), 18, 1'b1, "timeout");
        eng_mode = 0;
        run_txn(1, rnd(), rnd(), 4, 1'b0, "after_to");

        // Reset during WAIT of a client-0 transaction
        eng_mode = 2;
        a0 = rnd(); b0 = rnd();
        req0 = 1'b1;
        repeat (5) tick();
        check("rst_busy_before", (W+1)'(busy), 1);
        RST_N = 1'b0;
        req0  = 1'b0;
        tick();
        check_all_zero("midrst");
        RST_N = 1'b1;
        cnt = 0;
        repeat (25) begin
            tick();
            if (done0 === 1'b1 || done1 === 1'b1) cnt++;
        end
        check("midrst_no_done", (W+1)'(cnt), 0);

        eng_mode = 0;
        ta0 = rnd(); tb0 = rnd(); ta1 = rnd(); tb1 = rnd();
        a0 = ta0; b0 = tb0; a1 = ta1; b1 = tb1;
        req0 = 1'b1;
        req1 = 1'b1;
        wait_done(who, gap);
        check("post_rst_who", (W+1)'(who), 0);
        check("post_rst_lat", (W+1)'(gap), 4);
        check("post_rst_sum", s_out, model_sum(ta0, tb0));
        tick();
        req0 = 1'b0;
        wait_done(who, gap);
        check("post_rst_who2", (W+1)'(who), 1);
        check("post_rst_sum2", s_out, model_sum(ta1, tb1));
        tick();
        req1 = 1'b0;
        repeat (3) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
